// File: rtl/ddfs_pkg.sv
// Shared definitions for the ddfs generator and its frequency meter:
// default widths, measurement FSM states and window length helpers.
package ddfs_pkg;

    localparam int N_DEF = 8;
    localparam int M_DEF = 4;
    localparam int G_DEF = 2;

    localparam int WIN     = 2 ** (N_DEF + G_DEF);
    localparam int ARM_MAX = 2 ** (N_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } meter_state_t;

    function automatic int win_len(input int n, input int g);
        return 2 ** (n + g);
    endfunction

    function automatic int arm_len(input int n);
        return 2 ** (n + 1);
    endfunction

endpackage

// File: rtl/ddfs_edge_det.sv
// Rising-edge detector on the sign bit of an offset-binary sine stream.
module ddfs_edge_det #(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] sine,
    output logic         e
);

    logic s_q;
    logic sine_unused;

    // Only the sign carries zero-crossing information.
    assign sine_unused = ^sine[M-2:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= 1'b0;
        end else begin
            s_q <= sine[M-1];
        end
    end

    assign e = sine[M-1] & ~s_q;

endmodule

// File: rtl/ddfs_freq_meter.sv
// Recovers the ddfs frequency word by counting sign transitions over a
// transition-aligned window of 2^(N+G) clocks and dividing by 2^G.
module ddfs_freq_meter
    import ddfs_pkg::*;
#(
    parameter int N          = 8,
    parameter int M          = 4,
    parameter int G          = 2,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] sine,
    input  logic         start,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] fw_est,
    output logic         timeout,
    output logic         led
);

    localparam int CW = N + G;
    localparam logic [N:0]    ARM_LAST = (N + 1)'(arm_len(N) - 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(win_len(N, G) - 1);

    meter_state_t  state;
    logic [N:0]    arm_timer;
    logic [CW-1:0] win_cnt;
    logic [CW-1:0] edge_cnt;
    logic [CW-1:0] edge_next;
    logic          e;

    ddfs_edge_det #(.M(M)) u_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .sine  (sine),
        .e     (e)
    );

    // Saturating edge count including an edge in the current cycle.
    always_comb begin
        edge_next = edge_cnt;
        if (e && (edge_cnt != '1)) begin
            edge_next = edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            arm_timer <= '0;
            win_cnt   <= '0;
            edge_cnt  <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            fw_est    <= '0;
            timeout   <= 1'b0;
            led       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ARM;
                        busy      <= 1'b1;
                        arm_timer <= '0;
                    end
                end
                ST_ARM: begin
                    if (e) begin
                        // The arming edge itself opens the window, uncounted.
                        state    <= ST_GATE;
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                    end else if (arm_timer == ARM_LAST) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        valid   <= 1'b1;
                        fw_est  <= '0;
                        timeout <= 1'b1;
                        led     <= ~led;
                    end else begin
                        arm_timer <= arm_timer + 1'b1;
                    end
                end
                ST_GATE: begin
                    win_cnt  <= win_cnt + 1'b1;
                    edge_cnt <= edge_next;
                    if (win_cnt == WIN_LAST) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        valid   <= 1'b1;
                        fw_est  <= edge_next[CW-1:G];
                        timeout <= 1'b0;
                        led     <= ~led;
                    end
                end
                ST_DONE: begin
                    if (CONTINUOUS) begin
                        state     <= ST_ARM;
                        busy      <= 1'b1;
                        arm_timer <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddfs_freq_meter.sv
// Loopback bench: a behavioural ddfs drives two meters (one-shot and
// continuous); results are checked against the generating frequency word.
module tb_ddfs_freq_meter;
    import ddfs_pkg::*;

    localparam int N = N_DEF;
    localparam int M = M_DEF;
    localparam int G = G_DEF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         gen_rst_n = 1'b0;
    logic [N-1:0] fw = '0;
    logic [N-1:0] phase;
    logic [M-1:0] sine;
    logic         start0 = 1'b0;
    logic         start1 = 1'b0;
    logic         busy0, valid0, timeout0, led0;
    logic         busy1, valid1, timeout1, led1;
    logic [N-1:0] fw_est0, fw_est1;

    int total = 0;
    int bad = 0;
    logic         led_exp0 = 1'b0;
    logic         led_exp1 = 1'b0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    // Phase accumulator with a coarse offset-binary waveform: first half of
    // the phase circle is the positive half-wave.
    always @(posedge clk) begin
        if (!gen_rst_n) phase <= '0;
        else            phase <= phase + fw;
    end

    always_comb begin
        if (phase[N-1] == 1'b0) sine = M'(8 + int'(phase[N-2:N-4]));
        else                    sine = M'(7 - int'(phase[N-2:N-4]));
    end

    ddfs_freq_meter #(.N(N), .M(M), .G(G), .CONTINUOUS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sine(sine), .start(start0),
        .busy(busy0), .valid(valid0), .fw_est(fw_est0),
        .timeout(timeout0), .led(led0)
    );

    ddfs_freq_meter #(.N(N), .M(M), .G(G), .CONTINUOUS(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sine(sine), .start(start1),
        .busy(busy1), .valid(valid1), .fw_est(fw_est1),
        .timeout(timeout1), .led(led1)
    );

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, input int budget, output int lat, output bit ok);
        lat = 0;
        ok = 1'b0;
        while (lat < budget && !ok) begin
            @(negedge clk);
            lat++;
            if ((sel ? valid1 : valid0) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        gen_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({busy0, valid0, timeout0, led0} !== 4'b0) begin bad++; $display("FAIL reset_flags0 got=%b want=0000", {busy0, valid0, timeout0, led0}); end
        total++; if (fw_est0 !== '0) begin bad++; $display("FAIL reset_fw_est0 got=%0d want=0", fw_est0); end
        total++; if ({busy1, valid1, timeout1, led1} !== 4'b0) begin bad++; $display("FAIL reset_flags1 got=%b want=0000", {busy1, valid1, timeout1, led1}); end
        total++; if (fw_est1 !== '0) begin bad++; $display("FAIL reset_fw_est1 got=%0d want=0", fw_est1); end
        rst_n = 1'b1;
        gen_rst_n = 1'b1;
        led_exp0 = 1'b0;
        led_exp1 = 1'b0;
    endtask

    task automatic test_loopback(input logic [N-1:0] fw_v);
        int  lat;
        bit  ok;
        logic [N-1:0] want;
        fw = fw_v;
        exp_q.push_back(fw_v);
        repeat (4) @(negedge clk);
        pulse_start(1'b0);
        wait_valid(1'b0, ARM_MAX + WIN + 4, lat, ok);
        want = exp_q.pop_front();
        total++;
        if (!ok) begin
            bad++; $display("FAIL loop_valid fw=%0d got=none want=valid within %0d", fw_v, ARM_MAX + WIN + 2);
        end else begin
            led_exp0 = ~led_exp0;
            total++; if (fw_est0 !== want) begin bad++; $display("FAIL loop_fw_est got=%0d want=%0d", fw_est0, want); end
            total++; if (timeout0 !== 1'b0) begin bad++; $display("FAIL loop_timeout fw=%0d got=%b want=0", fw_v, timeout0); end
            total++; if (led0 !== led_exp0) begin bad++; $display("FAIL loop_led fw=%0d got=%b want=%b", fw_v, led0, led_exp0); end
            total++; if (lat < WIN + 1 || lat > ARM_MAX + WIN + 2) begin bad++; $display("FAIL loop_latency fw=%0d got=%0d want=%0d..%0d", fw_v, lat, WIN + 1, ARM_MAX + WIN + 2); end
            @(negedge clk);
            total++; if ({valid0, busy0} !== 2'b00) begin bad++; $display("FAIL loop_after got valid,busy=%b want=00", {valid0, busy0}); end
        end
    endtask

    task automatic test_sweep();
        logic [N-1:0] tbl[4];
        tbl[0] = 8'd1; tbl[1] = 8'd2; tbl[2] = 8'd64; tbl[3] = 8'd127;
        for (int i = 0; i < 4; i++) test_loopback(tbl[i]);
        for (int i = 0; i < 4; i++) test_loopback(N'($urandom_range(1, 127)));
    endtask

    task automatic test_timeout();
        int lat;
        bit ok;
        gen_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start(1'b0);
        wait_valid(1'b0, ARM_MAX + 50, lat, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL timeout_valid got=none want=valid at %0d", ARM_MAX);
        end else begin
            led_exp0 = ~led_exp0;
            total++; if (lat !== ARM_MAX) begin bad++; $display("FAIL timeout_latency got=%0d want=%0d", lat, ARM_MAX); end
            total++; if (fw_est0 !== '0) begin bad++; $display("FAIL timeout_fw_est got=%0d want=0", fw_est0); end
            total++; if (timeout0 !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b want=1", timeout0); end
            total++; if (led0 !== led_exp0) begin bad++; $display("FAIL timeout_led got=%b want=%b", led0, led_exp0); end
        end
        gen_rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        fw = 8'd2;
        repeat (4) @(negedge clk);
        pulse_start(1'b0);
        repeat (700) @(negedge clk);
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy0); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if ({busy0, valid0, timeout0, led0} !== 4'b0 || fw_est0 !== '0) begin
            bad++; $display("FAIL mid_reset got flags=%b fw_est=%0d want=0000/0", {busy0, valid0, timeout0, led0}, fw_est0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        led_exp0 = 1'b0;
        led_exp1 = 1'b0;
        test_loopback(8'd2);
    endtask

    task automatic test_back_to_back();
        int  lat;
        int  period;
        bit  ok;
        logic [N-1:0] fw_v;
        fw_v = N'($urandom_range(8, 127));
        fw = fw_v;
        period = (2 ** N) / int'(fw_v) + 1;
        repeat (4) @(negedge clk);
        pulse_start(1'b0);
        repeat (300) @(negedge clk);
        pulse_start(1'b0);
        wait_valid(1'b0, WIN + 100, lat, ok);
        lat = lat + 302;
        total++;
        if (!ok) begin
            bad++; $display("FAIL b2b_valid got=none want=valid");
        end else begin
            led_exp0 = ~led_exp0;
            total++; if (fw_est0 !== fw_v) begin bad++; $display("FAIL b2b_fw_est got=%0d want=%0d", fw_est0, fw_v); end
            total++; if (lat > WIN + 2 + period) begin bad++; $display("FAIL b2b_latency got=%0d want<=%0d", lat, WIN + 2 + period); end
            @(negedge clk);
            total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b want=0", busy0); end
        end
    endtask

    task automatic test_continuous();
        int lat;
        bit ok;
        fw = 8'd5;
        repeat (4) @(negedge clk);
        pulse_start(1'b1);
        wait_valid(1'b1, ARM_MAX + WIN + 4, lat, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL cont_valid1 got=none want=valid"); end
        else begin
            led_exp1 = ~led_exp1;
            total++; if (fw_est1 !== 8'd5) begin bad++; $display("FAIL cont_first got=%0d want=5", fw_est1); end
            total++; if (led1 !== led_exp1) begin bad++; $display("FAIL cont_led got=%b want=%b", led1, led_exp1); end
        end
        repeat (300) @(negedge clk);
        pulse_start(1'b1);
        fw = 8'd1;
        wait_valid(1'b1, WIN + 100, lat, ok);
        lat = lat + 302;
        total++;
        if (!ok) begin bad++; $display("FAIL cont_valid2 got=none want=valid"); end
        else begin
            total++; if (fw_est1 < 8'd1 || fw_est1 > 8'd5) begin bad++; $display("FAIL cont_second got=%0d want=1..5", fw_est1); end
            total++; if (lat > WIN + 60) begin bad++; $display("FAIL cont_restart got latency=%0d want<=%0d", lat, WIN + 60); end
        end
        wait_valid(1'b1, ARM_MAX + WIN + 4, lat, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL cont_valid3 got=none want=valid"); end
        else begin
            total++; if (fw_est1 !== 8'd1) begin bad++; $display("FAIL cont_third got=%0d want=1", fw_est1); end
            total++; if (timeout1 !== 1'b0) begin bad++; $display("FAIL cont_timeout got=%b want=0", timeout1); end
        end
    endtask

    initial begin
        test_reset();
        test_loopback(8'd5);
        test_sweep();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_continuous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
